// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational RV format decode feeding a
// two-entry (main + skid) output buffer with valid/ready handshakes and flush.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit U_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_data_i,
    output logic            imm_valid_o,
    input  logic            imm_ready_i,
    output logic [XLEN-1:0] imm_data_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [31:0]     imm32_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_fmt_s;
    logic            dec_ill_s;

    state_e          state_r;
    state_e          state_nxt_s;
    logic            valid_r;
    logic            ready_r;
    logic            in_s;
    logic            out_s;
    logic            load_main_s;
    logic            load_skid_s;
    logic            move_skid_s;

    logic [XLEN-1:0] main_imm_r;
    logic [2:0]      main_fmt_r;
    logic            main_ill_r;
    logic [XLEN-1:0] skid_imm_r;
    logic [2:0]      skid_fmt_r;
    logic            skid_ill_r;

    // Format decode and 32-bit immediate assembly from the incoming word.
    always_comb begin
        imm32_s   = 32'd0;
        dec_fmt_s = FMT_ILL;
        dec_ill_s = 1'b1;
        if (instr_data_i[1:0] == 2'b11) begin
            case (instr_data_i[6:2])
                5'b01100: begin
                    dec_fmt_s = FMT_R;
                    dec_ill_s = 1'b0;
                end
                5'b00100, 5'b00000, 5'b11001: begin
                    imm32_s   = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
                    dec_fmt_s = FMT_I;
                    dec_ill_s = 1'b0;
                end
                5'b01000: begin
                    imm32_s   = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
                    dec_fmt_s = FMT_S;
                    dec_ill_s = 1'b0;
                end
                5'b11000: begin
                    imm32_s   = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                                 instr_data_i[30:25], instr_data_i[11:8], 1'b0};
                    dec_fmt_s = FMT_B;
                    dec_ill_s = 1'b0;
                end
                5'b11011: begin
                    imm32_s   = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                                 instr_data_i[20], instr_data_i[30:21], 1'b0};
                    dec_fmt_s = FMT_J;
                    dec_ill_s = 1'b0;
                end
                5'b01101, 5'b00101: begin
                    if (U_EN) begin
                        imm32_s   = {instr_data_i[31:12], 12'd0};
                        dec_fmt_s = FMT_U;
                        dec_ill_s = 1'b0;
                    end else begin
                        imm32_s   = 32'd0;
                    end
                end
                default: begin
                    imm32_s   = 32'd0;
                end
            endcase
        end else begin
            imm32_s = 32'd0;
        end
    end

    // Every format's immediate is sign-extended from bit 31, so widening is a signed cast.
    assign dec_imm_s = XLEN'($signed(imm32_s));

    assign in_s  = instr_valid_i & ready_r;
    assign out_s = valid_r & imm_ready_i;

    // Buffer occupancy next-state and entry load selects; flush overrides all.
    always_comb begin
        state_nxt_s = state_r;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_s) begin
                        state_nxt_s = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_s && out_s) begin
                        load_main_s = 1'b1;
                    end else if (in_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (out_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_s) begin
                        state_nxt_s = ST_ONE;
                        move_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State plus handshake flags registered straight from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != ST_EMPTY);
            ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    // Main and skid payload registers; valids alone track occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_imm_r <= '0;
            main_fmt_r <= 3'd0;
            main_ill_r <= 1'b0;
            skid_imm_r <= '0;
            skid_fmt_r <= 3'd0;
            skid_ill_r <= 1'b0;
        end else begin
            if (load_main_s) begin
                main_imm_r <= dec_imm_s;
                main_fmt_r <= dec_fmt_s;
                main_ill_r <= dec_ill_s;
            end else if (move_skid_s) begin
                main_imm_r <= skid_imm_r;
                main_fmt_r <= skid_fmt_r;
                main_ill_r <= skid_ill_r;
            end
            if (load_skid_s) begin
                skid_imm_r <= dec_imm_s;
                skid_fmt_r <= dec_fmt_s;
                skid_ill_r <= dec_ill_s;
            end
        end
    end

    assign instr_ready_o = ready_r;
    assign imm_valid_o   = valid_r;
    assign imm_data_o    = main_imm_r;
    assign fmt_o         = main_fmt_r;
    assign illegal_o     = main_ill_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three configurations (32-bit, 64-bit,
// 64-bit without U-type) share one stimulus stream of hand-decoded vectors.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = 32'd0;
    logic        imm_ready = 1'b0;

    logic        rdy32, rdy64, rdyu0;
    logic        val32, val64, valu0;
    logic [31:0] imm32;
    logic [63:0] imm64, immu0;
    logic [2:0]  fmt32, fmt64, fmtu0;
    logic        ill32, ill64, illu0;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t sb_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .U_EN(1'b1)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(rdy32), .instr_data_i(instr_data),
        .imm_valid_o(val32), .imm_ready_i(imm_ready),
        .imm_data_o(imm32), .fmt_o(fmt32), .illegal_o(ill32));

    imm_gen_pipe #(.XLEN(64), .U_EN(1'b1)) dut64 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(rdy64), .instr_data_i(instr_data),
        .imm_valid_o(val64), .imm_ready_i(imm_ready),
        .imm_data_o(imm64), .fmt_o(fmt64), .illegal_o(ill64));

    imm_gen_pipe #(.XLEN(64), .U_EN(1'b0)) dutu0 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(rdyu0), .instr_data_i(instr_data),
        .imm_valid_o(valu0), .imm_ready_i(imm_ready),
        .imm_data_o(immu0), .fmt_o(fmtu0), .illegal_o(illu0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid32"}, {63'd0, val32}, 64'd0);
        chk({tag, "_ready32"}, {63'd0, rdy32}, 64'd1);
        chk({tag, "_imm32"}, {32'd0, imm32}, 64'd0);
        chk({tag, "_fmt32"}, {61'd0, fmt32}, 64'd0);
        chk({tag, "_ill32"}, {63'd0, ill32}, 64'd0);
        chk({tag, "_valid64"}, {63'd0, val64}, 64'd0);
        chk({tag, "_ready64"}, {63'd0, rdy64}, 64'd1);
        chk({tag, "_imm64"}, imm64, 64'd0);
    endtask

    // Output-side monitor: pops on every output handshake, tracks input accepts.
    always @(negedge clk) begin
        vec_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (val32 && imm_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", {32'd0, imm32}, 64'd0);
                    chk("unexpected_output_valid", {63'd0, val32}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("imm32", {32'd0, imm32}, {32'd0, e.imm32});
                    chk("fmt32", {61'd0, fmt32}, {61'd0, e.fmt});
                    chk("ill32", {63'd0, ill32}, {63'd0, e.ill});
                    chk("valid64", {63'd0, val64}, 64'd1);
                    chk("imm64", imm64, e.imm64);
                    chk("fmt64", {61'd0, fmt64}, {61'd0, e.fmt});
                    chk("ill64", {63'd0, ill64}, {63'd0, e.ill});
                    chk("valid_nou", {63'd0, valu0}, 64'd1);
                    if (e.fmt == 3'd4) begin
                        chk("imm_nou", immu0, 64'd0);
                        chk("fmt_nou", {61'd0, fmtu0}, 64'd7);
                        chk("ill_nou", {63'd0, illu0}, 64'd1);
                    end else begin
                        chk("imm_nou", immu0, e.imm64);
                        chk("fmt_nou", {61'd0, fmtu0}, {61'd0, e.fmt});
                        chk("ill_nou", {63'd0, illu0}, {63'd0, e.ill});
                    end
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (instr_valid && rdy32) begin
                for (int i = 0; i < 13; i++) begin
                    if (vecs[i].instr == instr_data) begin
                        sb_q.push_back(vecs[i]);
                        break;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        int   guard = 0;
        logic acc;
        instr_valid = 1'b1;
        instr_data  = ins;
        forever begin
            @(negedge clk);
            acc = rdy32 && !flush;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 50) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0}; // sw -4
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0}; // beq -8
        vecs[3]  = '{32'h001000EF, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0}; // jal +2048
        vecs[4]  = '{32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui 0x80000
        vecs[5]  = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0}; // add
        vecs[6]  = '{32'hFFF00090, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1}; // bad [1:0]
        vecs[7]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1}; // bad opcode
        vecs[8]  = '{32'h00001297, 32'h00001000, 64'h0000000000001000, 3'd4, 1'b0}; // auipc 1
        vecs[9]  = '{32'h80002083, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0}; // lw -2048
        vecs[10] = '{32'h7FF00067, 32'h000007FF, 64'h00000000000007FF, 3'd1, 1'b0}; // jalr 2047
        vecs[11] = '{32'h00000463, 32'h00000008, 64'h0000000000000008, 3'd3, 1'b0}; // beq +8
        vecs[12] = '{32'h00000013, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0}; // nop

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imm_ready = 1'b1;

        send(vecs[0].instr);
        @(negedge clk);
        chk("latency_valid", {63'd0, val32}, 64'd1);
        chk("latency_imm", {32'd0, imm32}, 64'hFFFFFFFF);
        @(posedge clk);
        #1;

        for (int i = 1; i <= 11; i++) send(vecs[i].instr);
        drain_check("stream_drain");

        // Back-pressure: second instruction lands in skid, third waits.
        imm_ready = 1'b0;
        send(vecs[1].instr);
        send(vecs[2].instr);
        @(negedge clk);
        chk("bp_ready_low", {63'd0, rdy32}, 64'd0);
        chk("bp_valid", {63'd0, val32}, 64'd1);
        held = imm32;
        @(negedge clk);
        chk("bp_stable", {32'd0, imm32}, {32'd0, held});
        @(posedge clk);
        #1;
        fork
            send(vecs[3].instr);
            begin
                repeat (3) @(posedge clk);
                #1;
                imm_ready = 1'b1;
            end
        join
        drain_check("bp_drain");

        // Flush while FULL with a concurrent input that must vanish.
        imm_ready = 1'b0;
        send(vecs[9].instr);
        send(vecs[10].instr);
        instr_valid = 1'b1;
        instr_data  = vecs[4].instr;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'd0, val32}, 64'd0);
        chk("flush_ready", {63'd0, rdy32}, 64'd1);
        @(posedge clk);
        #1;
        imm_ready = 1'b1;
        send(vecs[11].instr);
        drain_check("flush_drain");

        // Asynchronous reset mid-cycle while FULL.
        imm_ready = 1'b0;
        send(vecs[0].instr);
        send(vecs[5].instr);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imm_ready = 1'b1;
        send(vecs[12].instr);
        drain_check("rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
